// File: rtl/dmem_responder.sv
// Data-memory responder: word SRAM with byte-lane writes, range check and a
// ready/error handshake after WAIT_STATES wait cycles. Optional MMIO cycle counter: DMEM_RESPONDER_MMIO_EN.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        dmem_error
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [32:0] SPAN      = 33'd1 << (ADDR_WIDTH + 2);

    state_t      state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;
    logic        accept;
    logic        commit;

    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        rd_q, wr_q;

    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_rd, cur_wr;

    logic [32:0]           offset;
    logic                  in_range;
    logic                  is_mmio;
    logic                  access_err;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           rd_value;

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                if (dmem_read || dmem_write) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign commit = (state_next == RESP);

    // With no wait states the commit edge is also the acceptance edge, so
    // the live request must be used instead of the latched copy.
    always_comb begin
        if (state == IDLE) begin
            cur_addr  = dmem_addr;
            cur_wdata = dmem_wdata;
            cur_be    = dmem_byte_enable;
            cur_rd    = dmem_read;
            cur_wr    = dmem_write;
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
            cur_rd    = rd_q;
            cur_wr    = wr_q;
        end
    end

    // Bounds are word-aligned, so comparing the full byte address is exact.
    assign offset   = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    assign in_range = !offset[32] && ({1'b0, offset[31:0]} < SPAN);
    assign idx      = offset[ADDR_WIDTH+1:2];

`ifdef DMEM_RESPONDER_MMIO_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign is_mmio  = (cur_addr[31:2] == 30'h3FFF_FFFC);
    assign rd_value = is_mmio ? cycle_cnt : mem[idx];
`else
    assign is_mmio  = 1'b0;
    assign rd_value = mem[idx];
`endif

    assign access_err = (cur_rd && cur_wr) || (!is_mmio && !in_range);
    assign mem_we     = commit && cur_wr && !access_err && !is_mmio;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            dmem_rdata <= '0;
            dmem_ready <= 1'b0;
            dmem_error <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= dmem_addr;
                wdata_q <= dmem_wdata;
                be_q    <= dmem_byte_enable;
                rd_q    <= dmem_read;
                wr_q    <= dmem_write;
            end
            dmem_ready <= commit;
            dmem_error <= commit && access_err;
            if (commit) begin
                if (access_err) begin
                    dmem_rdata <= '0;
                end else if (cur_rd) begin
                    dmem_rdata <= rd_value;
                end
            end
        end
    end

endmodule
